// File: rtl/obj_centroid_calc.sv
// Foreground centroid of a binarised camera frame: accumulates pixel count and
// coordinate sums per frame, then divides them serially to report the centroid.
module obj_centroid_calc #(
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_vsync,
    input  logic        frame_href,
    input  logic        frame_valid,
    input  logic [7:0]  binary_in,
    output logic        obj_detected,
    output logic        obj_none,
    output logic [10:0] obj_x,
    output logic [10:0] obj_y,
    output logic [19:0] obj_pixels,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    localparam logic [19:0] MIN_CNT   = 20'(MIN_PIXELS);
    localparam logic [10:0] COORD_MAX = '1;
    localparam logic [19:0] COUNT_MAX = '1;
    localparam logic [4:0]  LAST_BIT  = 5'd30;

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        line_pix_q, line_pix_d;
    logic [19:0] count_q, count_d;
    logic [30:0] sum_x_q, sum_x_d;
    logic [30:0] sum_y_q, sum_y_d;
    logic [19:0] snap_count_q, snap_count_d;
    logic [30:0] snap_sum_y_q, snap_sum_y_d;
    logic [19:0] rem_q, rem_d;
    logic [30:0] dq_q, dq_d;
    logic [4:0]  bit_q, bit_d;
    logic [10:0] quo_x_q, quo_x_d;
    logic [10:0] obj_x_q, obj_x_d;
    logic [10:0] obj_y_q, obj_y_d;
    logic [19:0] obj_pixels_q, obj_pixels_d;
    logic        obj_none_q, obj_none_d;

    logic        boundary;
    logic        pix;
    logic        href_fall;
    logic        fg;
    logic [20:0] rem_shift;
    logic        rem_ge;
    logic [19:0] rem_next;
    logic [30:0] dq_next;

    always_comb begin
        boundary  = frame_vsync & ~vsync_q;
        pix       = frame_href & frame_valid;
        href_fall = href_q & ~frame_href;
        fg        = pix & ~frame_vsync & (binary_in != 8'd0);

        // dq holds the remaining dividend bits on top and the quotient bits shifted in below
        rem_shift = {rem_q, dq_q[30]};
        rem_ge    = rem_shift >= {1'b0, snap_count_q};
        rem_next  = rem_ge ? 20'(rem_shift - {1'b0, snap_count_q}) : rem_shift[19:0];
        dq_next   = {dq_q[29:0], rem_ge};

        vsync_d      = frame_vsync;
        href_d       = frame_href;
        x_d          = x_q;
        y_d          = y_q;
        line_pix_d   = line_pix_q;
        count_d      = count_q;
        sum_x_d      = sum_x_q;
        sum_y_d      = sum_y_q;
        snap_count_d = snap_count_q;
        snap_sum_y_d = snap_sum_y_q;
        rem_d        = rem_q;
        dq_d         = dq_q;
        bit_d        = bit_q;
        quo_x_d      = quo_x_q;
        obj_x_d      = obj_x_q;
        obj_y_d      = obj_y_q;
        obj_pixels_d = obj_pixels_q;
        obj_none_d   = 1'b0;
        state_d      = state_q;

        if (href_fall) begin
            x_d = '0;
        end else if (pix && x_q != COORD_MAX) begin
            x_d = x_q + 11'd1;
        end

        if (href_fall) begin
            line_pix_d = 1'b0;
        end else if (pix && !frame_vsync) begin
            line_pix_d = 1'b1;
        end

        if (boundary) begin
            y_d = '0;
        end else if (href_fall && line_pix_q && y_q != COORD_MAX) begin
            y_d = y_q + 11'd1;
        end

        if (boundary) begin
            snap_count_d = count_q;
            snap_sum_y_d = sum_y_q;
            obj_pixels_d = count_q;
            count_d      = '0;
            sum_x_d      = '0;
            sum_y_d      = '0;
        end else if (fg && count_q != COUNT_MAX) begin
            count_d = count_q + 20'd1;
            sum_x_d = sum_x_q + {20'd0, x_q};
            sum_y_d = sum_y_q + {20'd0, y_q};
        end

        case (state_q)
            DIV_X: begin
                rem_d = rem_next;
                dq_d  = dq_next;
                bit_d = bit_q + 5'd1;
                if (bit_q == LAST_BIT) begin
                    quo_x_d = dq_next[10:0];
                    dq_d    = snap_sum_y_q;
                    rem_d   = '0;
                    bit_d   = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                rem_d = rem_next;
                dq_d  = dq_next;
                bit_d = bit_q + 5'd1;
                if (bit_q == LAST_BIT) begin
                    obj_x_d = quo_x_q;
                    obj_y_d = dq_next[10:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new frame boundary always wins: any division in flight is abandoned
        if (boundary) begin
            rem_d = '0;
            bit_d = '0;
            dq_d  = sum_x_q;
            if (count_q >= MIN_CNT) begin
                state_d = DIV_X;
            end else begin
                state_d    = IDLE;
                obj_none_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            // Treat vsync as already high so a frame gap at release is not a boundary
            vsync_q      <= 1'b1;
            href_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            line_pix_q   <= 1'b0;
            count_q      <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            snap_count_q <= '0;
            snap_sum_y_q <= '0;
            rem_q        <= '0;
            dq_q         <= '0;
            bit_q        <= '0;
            quo_x_q      <= '0;
            obj_x_q      <= '0;
            obj_y_q      <= '0;
            obj_pixels_q <= '0;
            obj_none_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_pix_q   <= line_pix_d;
            count_q      <= count_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            snap_count_q <= snap_count_d;
            snap_sum_y_q <= snap_sum_y_d;
            rem_q        <= rem_d;
            dq_q         <= dq_d;
            bit_q        <= bit_d;
            quo_x_q      <= quo_x_d;
            obj_x_q      <= obj_x_d;
            obj_y_q      <= obj_y_d;
            obj_pixels_q <= obj_pixels_d;
            obj_none_q   <= obj_none_d;
        end
    end

    assign obj_detected = (state_q == DONE);
    assign busy         = (state_q == DIV_X) || (state_q == DIV_Y);
    assign obj_none     = obj_none_q;
    assign obj_x        = obj_x_q;
    assign obj_y        = obj_y_q;
    assign obj_pixels   = obj_pixels_q;

endmodule

// File: tb/tb_obj_centroid_calc.sv
// Scoreboard bench for obj_centroid_calc: dut_a uses MIN_PIXELS=1, dut_b the default 64.
module tb_obj_centroid_calc;

    typedef struct {
        bit     none;
        longint x;
        longint y;
        longint pix;
        longint cyc;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        frame_vsync;
    logic        frame_href;
    logic        frame_valid;
    logic [7:0]  binary_in;

    logic        det_a, none_a, busy_a;
    logic [10:0] x_a, y_a;
    logic [19:0] pix_a;
    logic        det_b, none_b, busy_b;
    logic [10:0] x_b, y_b;
    logic [19:0] pix_b;

    obj_centroid_calc #(.MIN_PIXELS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_href(frame_href),
        .frame_valid(frame_valid), .binary_in(binary_in), .obj_detected(det_a),
        .obj_none(none_a), .obj_x(x_a), .obj_y(y_a), .obj_pixels(pix_a), .busy(busy_a)
    );

    obj_centroid_calc dut_b (
        .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_href(frame_href),
        .frame_valid(frame_valid), .binary_in(binary_in), .obj_detected(det_b),
        .obj_none(none_b), .obj_x(x_b), .obj_y(y_b), .obj_pixels(pix_b), .busy(busy_b)
    );

    ev_t    q_a[$];
    ev_t    q_b[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    longint mcnt = 0, msx = 0, msy = 0;
    longint la_x = 0, la_y = 0, lb_x = 0, lb_y = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic det, input logic none,
                       input logic [10:0] ox, input logic [10:0] oy, input logic [19:0] op);
        ev_t   e;
        bit    have;
        string nm;
        nm   = (d == 0) ? "dutA" : "dutB";
        have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        if (have) e = (d == 0) ? q_a[0] : q_b[0];
        if (det || none) begin
            if (!have) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s unexpected pulse: got det=%0b none=%0b, required no pulse (cycle %0d)",
                         nm, det, none, cyc);
            end else begin
                if (d == 0) q_a.delete(0); else q_b.delete(0);
                chk({nm, " event cycle"}, cyc, e.cyc);
                chk({nm, " obj_none"}, longint'(none), longint'(e.none));
                chk({nm, " obj_detected"}, longint'(det), longint'(!e.none));
                chk({nm, " obj_x"}, longint'(ox), e.x);
                chk({nm, " obj_y"}, longint'(oy), e.y);
                chk({nm, " obj_pixels"}, longint'(op), e.pix);
            end
        end else if (have && e.cyc < cyc) begin
            if (d == 0) q_a.delete(0); else q_b.delete(0);
            n_cmp++;
            n_fail++;
            $display("FAIL %s missing event: got no pulse, required %s at cycle %0d",
                     nm, e.none ? "obj_none" : "obj_detected", e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, det_a, none_a, x_a, y_a, pix_a);
            mon(1, det_b, none_b, x_b, y_b, pix_b);
        end
    end

    // Builds the expected responses of both instances from the modelled frame sums
    task automatic expect_frame(input longint b, input bit abort_a);
        ev_t e;
        if (mcnt >= 1) begin
            if (!abort_a) begin
                e.none = 0; e.x = msx / mcnt; e.y = msy / mcnt; e.pix = mcnt; e.cyc = b + 63;
                q_a.push_back(e);
                la_x = e.x; la_y = e.y;
            end
        end else begin
            e.none = 1; e.x = la_x; e.y = la_y; e.pix = mcnt; e.cyc = b + 1;
            q_a.push_back(e);
        end
        if (mcnt >= 64) begin
            e.none = 0; e.x = msx / mcnt; e.y = msy / mcnt; e.pix = mcnt; e.cyc = b + 63;
            q_b.push_back(e);
            lb_x = e.x; lb_y = e.y;
        end else begin
            e.none = 1; e.x = lb_x; e.y = lb_y; e.pix = mcnt; e.cyc = b + 1;
            q_b.push_back(e);
        end
        mcnt = 0; msx = 0; msy = 0;
    endtask

    task automatic send_frame(input int ncols, input int nrows,
                              input int x0, input int x1, input int y0, input int y1);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ncols; c++) begin
                @(negedge clk);
                frame_href  = 1'b1;
                frame_valid = 1'b1;
                if (c >= x0 && c <= x1 && r >= y0 && r <= y1) begin
                    binary_in = 8'hA5;
                    mcnt++;
                    msx += (c > 2047) ? 2047 : c;
                    msy += r;
                end else begin
                    binary_in = 8'h00;
                end
            end
            @(negedge clk);
            frame_href  = 1'b0;
            frame_valid = 1'b0;
            binary_in   = 8'h00;
            @(negedge clk);
        end
    endtask

    task automatic boundary(input bit abort_a, output longint b);
        @(negedge clk);
        frame_vsync = 1'b1;
        b = cyc;
        expect_frame(b, abort_a);
        @(negedge clk);
        frame_vsync = 1'b0;
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " dutA obj_x"}, longint'(x_a), 0);
        chk({tag, " dutA obj_y"}, longint'(y_a), 0);
        chk({tag, " dutA obj_pixels"}, longint'(pix_a), 0);
        chk({tag, " dutA obj_detected"}, longint'(det_a), 0);
        chk({tag, " dutA obj_none"}, longint'(none_a), 0);
        chk({tag, " dutA busy"}, longint'(busy_a), 0);
        chk({tag, " dutB obj_x"}, longint'(x_b), 0);
        chk({tag, " dutB obj_y"}, longint'(y_b), 0);
        chk({tag, " dutB obj_pixels"}, longint'(pix_b), 0);
        chk({tag, " dutB obj_detected"}, longint'(det_b), 0);
        chk({tag, " dutB obj_none"}, longint'(none_b), 0);
        chk({tag, " dutB busy"}, longint'(busy_b), 0);
    endtask

    initial begin
        longint b, b2;
        rst_n       = 1'b0;
        frame_vsync = 1'b0;
        frame_href  = 1'b0;
        frame_valid = 1'b0;
        binary_in   = 8'h00;
        repeat (4) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single pixel at (10,5)
        send_frame(11, 6, 10, 10, 5, 5);
        boundary(0, b);
        repeat (3) @(negedge clk);
        chk("dutA busy in division", longint'(busy_a), 1);
        chk("dutB busy while idle", longint'(busy_b), 0);
        wait_until(b + 70);
        chk("dutA busy after done", longint'(busy_a), 0);

        // 4x4 block at x 100..103, y 50..53
        send_frame(104, 54, 100, 103, 50, 53);
        boundary(0, b);
        wait_until(b + 70);

        // 63 pixels: one short of the default threshold
        send_frame(9, 7, 0, 8, 0, 6);
        boundary(0, b);
        wait_until(b + 70);

        // 64 pixels: exactly at the default threshold
        send_frame(8, 8, 0, 7, 0, 7);
        boundary(0, b);
        wait_until(b + 70);

        // second boundary 20 cycles into the first division
        send_frame(22, 4, 20, 21, 2, 3);
        boundary(1, b);
        send_frame(8, 1, 6, 7, 0, 0);
        wait_until(b + 19);
        chk("dutA busy before abort", longint'(busy_a), 1);
        boundary(0, b2);
        wait_until(b2 + 70);

        // reset pulse during DIV_Y, with partial next-frame pixels accumulated
        send_frame(4, 2, 3, 3, 1, 1);
        boundary(1, b);
        send_frame(5, 1, 0, 4, 0, 0);
        wait_until(b + 40);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0; msx = 0; msy = 0;
        la_x = 0; la_y = 0; lb_x = 0; lb_y = 0;
        check_zero("mid-div reset");
        repeat (80) @(negedge clk);
        chk("dutA obj_x after reset idle", longint'(x_a), 0);

        // first frame after reset
        send_frame(8, 3, 7, 7, 2, 2);
        boundary(0, b);
        wait_until(b + 70);

        // 2100-pixel line, foreground beyond column 2047
        send_frame(2100, 1, 2040, 2099, 0, 0);
        boundary(0, b);
        wait_until(b + 70);

        repeat (10) @(negedge clk);
        chk("dutA pending events", longint'(q_a.size()), 0);
        chk("dutB pending events", longint'(q_b.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required end of test within time limit");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/obj_centroid_calc.md
OBJ_CENTROID_CALC -- requirements
Module: obj_centroid_calc

Interface
REQ-001 SHALL have parameter MIN_PIXELS, default 64: minimum foreground pixel count per frame for a valid object; legal range 1..1048575.
REQ-002 SHALL have port clk  input  1: pixel clock (cam_pclk domain); the only clock.
REQ-003 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-004 SHALL have port frame_vsync  input  1: frame sync, active high between frames.
REQ-005 SHALL have port frame_href  input  1: line valid, active high.
REQ-006 SHALL have port frame_valid  input  1: qualifies binary_in for one pixel.
REQ-007 SHALL have port binary_in  input  8: binarised pixel; nonzero = foreground.
REQ-008 SHALL have port obj_detected  output  1: one-cycle pulse, new centroid valid.
REQ-009 SHALL have port obj_none  output  1: one-cycle pulse, frame had fewer than MIN_PIXELS foreground pixels.
REQ-010 SHALL have port obj_x  output  11: centroid column, held until next obj_detected.
REQ-011 SHALL have port obj_y  output  11: centroid row, held until next obj_detected.
REQ-012 SHALL have port obj_pixels  output  20: foreground count of last evaluated frame.
REQ-013 SHALL have port busy  output  1: high while a division is in progress.

Function
REQ-014 Pixel column counter x SHALL start at 0 each line, increment by 1 after each frame_valid cycle while frame_href=1, saturate at 2047, clear on frame_href falling edge.
REQ-015 Row counter y SHALL increment on each frame_href falling edge that followed ≥1 valid pixel, saturate at 2047, clear at frame boundary.
REQ-016 Frame boundary SHALL be the cycle where frame_vsync=1 and its 1-cycle registered copy=0.
REQ-017 Pixels with frame_vsync=1 SHALL be ignored.
REQ-018 For each valid foreground pixel: count += 1 (20 bit), sum_x += x, sum_y += y (31 bit each); when count = 1048575 all three accumulators SHALL hold (no wrap).
REQ-019 At the boundary edge: count/sum_x/sum_y SHALL be copied into snapshot registers, accumulators and y SHALL clear, obj_pixels SHALL load the snapshot count.
REQ-020 State machine states IDLE, DIV_X, DIV_Y, DONE; reset state IDLE.
REQ-021 Boundary with snapshot count ≥ MIN_PIXELS: any state -> DIV_X; otherwise: any state -> IDLE and obj_none=1 in the next cycle.
REQ-022 DIV_X SHALL run a restoring divide sum_x/count, one quotient bit per cycle, 31 cycles, then -> DIV_Y (31 cycles, sum_y/count) -> DONE (1 cycle) -> IDLE.
REQ-023 Quotient SHALL be floor; the low 11 quotient bits SHALL drive obj_x/obj_y, loaded on entry to DONE.
REQ-024 obj_detected SHALL be 1 exactly during DONE, 63 cycles after the boundary edge; obj_x/obj_y change only in that same cycle.
REQ-025 Boundary during DIV_X/DIV_Y/DONE SHALL abort the current division, drop its result (no obj_detected), and restart per REQ-021 with the new snapshot.
REQ-026 busy SHALL be 1 in DIV_X and DIV_Y, 0 otherwise.
REQ-027 Accumulation SHALL continue for the new frame while a division is running.

Reset
REQ-028 On rst_n=0 at a clk edge: state IDLE; all counters, accumulators, snapshots cleared; obj_detected=0, obj_none=0, busy=0, obj_x=0, obj_y=0, obj_pixels=0.
REQ-029 Reset mid-division SHALL discard the division; no pulse after release.
REQ-030 After release, first boundary SHALL evaluate only pixels received after release.

Verification
REQ-031 MIN_PIXELS=1, single foreground pixel at (10,5), then boundary -> obj_detected 63 cycles later, obj_x=10, obj_y=5, obj_pixels=1.
REQ-032 4x4 block x 100..103, y 50..53 -> obj_pixels=16, obj_x=101 (1624/16 floored), obj_y=51.
REQ-033 Default MIN_PIXELS, 63 foreground pixels -> obj_none pulse one cycle after boundary, no obj_detected, obj_x/obj_y unchanged.
REQ-034 Second boundary 20 cycles into DIV_X -> first result never reported; single obj_detected 63 cycles after second boundary with second frame's centroid.
REQ-035 rst_n low for 1 cycle during DIV_Y -> all outputs 0, busy=0, no obj_detected until next valid frame.
REQ-036 Foreground at x>2047 (line of 2100 pixels) -> x saturates, obj_x ≤ 2047, no accumulator wrap.
